// File: rtl/uart_frame_tx.sv
// uart_frame_tx: serializes accepted bytes as UART frames (start, 8 data bits
// LSB-first, optional even parity, stop) and flags routing/programming frames
// by holding prog high for the whole frame.
//
// Ports:
//   clk       in   single clock, all state updates on posedge
//   rst_n     in   synchronous active-low reset
//   tx_data   in   byte to send, sampled on the accept edge
//   tx_prog   in   marks the byte as a programming frame, sampled with tx_data
//   tx_valid  in   request to send
//   tx_ready  out  block can accept a byte this cycle
//   txd       out  serial line, idle high
//   prog      out  high for the full duration of a programming frame
//   busy      out  frame in progress (START..STOP)
module uart_frame_tx #(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned PARITY_EN    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_prog,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       txd,
    output logic       prog,
    output logic       busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic             txd_q, txd_d;
    logic             prog_q, prog_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic             bit_done_c;

    // Last clock of the current serial bit.
    assign bit_done_c = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    // Next-state and registered-output computation; outputs are set for the
    // state being entered so txd/prog/busy change on the same edge as state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        txd_d   = txd_q;
        prog_d  = prog_q;
        busy_d  = busy_q;
        ready_d = ready_q;

        case (state_q)
            S_IDLE: begin
                if (tx_valid && ready_q) begin
                    state_d = S_START;
                    shift_d = tx_data;
                    par_d   = ^tx_data;
                    cnt_d   = '0;
                    bit_d   = '0;
                    txd_d   = 1'b0;
                    prog_d  = tx_prog;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                end
            end
            S_START: begin
                if (bit_done_c) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                    txd_d   = shift_q[0];
                end else begin
                    cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                end
            end
            S_DATA: begin
                if (bit_done_c) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    bit_d   = 3'(bit_q + 3'd1);
                    if (bit_q == 3'd7) begin
                        if (PARITY_EN != 0) begin
                            state_d = S_PARITY;
                            txd_d   = par_q;
                        end else begin
                            state_d = S_STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        // Next data bit is the one that shifts into position 0.
                        txd_d = shift_q[1];
                    end
                end else begin
                    cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                end
            end
            S_PARITY: begin
                if (bit_done_c) begin
                    cnt_d   = '0;
                    state_d = S_STOP;
                    txd_d   = 1'b1;
                end else begin
                    cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                end
            end
            S_STOP: begin
                if (bit_done_c) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    txd_d   = 1'b1;
                    prog_d  = 1'b0;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                txd_d   = 1'b1;
                prog_d  = 1'b0;
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers; reset abandons any frame in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            prog_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
            prog_q  <= prog_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    assign tx_ready = ready_q;
    assign txd      = txd_q;
    assign prog     = prog_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Testbench for uart_frame_tx: table of hand-derived frames, directed corner
// sequences, and randomized traffic checked every cycle against a frame-position
// reference model. Second instance covers CLKS_PER_BIT=1 without parity.
module tb_uart_frame_tx;

    localparam int C0 = 4;
    localparam int F0 = 44;

    logic       clk;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_prog;
    logic       tx_valid;
    logic       tx_ready, txd, prog, busy;

    logic [7:0] d1_data;
    logic       d1_prog;
    logic       d1_valid;
    logic       d1_ready, d1_txd, d1_progo, d1_busy;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: position inside the frame (0 = idle, 1..F0 = cycle of frame).
    int         m_pos = 0;
    logic [7:0] m_data = 8'h00;
    logic       m_prog = 1'b0;

    typedef struct {
        logic [7:0]  data;
        logic        prog;
        logic [10:0] frame;   // bit k = serial bit k (0 = start, 10 = stop)
    } vec_t;

    vec_t tbl[8];

    uart_frame_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_prog(tx_prog),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .txd(txd), .prog(prog), .busy(busy)
    );

    uart_frame_tx #(.CLKS_PER_BIT(1), .PARITY_EN(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .tx_data(d1_data), .tx_prog(d1_prog),
        .tx_valid(d1_valid), .tx_ready(d1_ready), .txd(d1_txd), .prog(d1_progo), .busy(d1_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic frame_bit(input logic [7:0] d, input bit pe, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (k == 9 && pe) return ^d;
        return 1'b1;
    endfunction

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got {txd,prog,busy,rdy}=%b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    // One clock: advance the model with the inputs present at the edge, then
    // compare the primary instance against it 1 ns later.
    task automatic step();
        logic [3:0] exp;
        @(posedge clk);
        if (!rst_n) begin
            m_pos = 0;
        end else if (m_pos == 0) begin
            if (tx_valid) begin
                m_pos  = 1;
                m_data = tx_data;
                m_prog = tx_prog;
            end
        end else if (m_pos == F0) begin
            m_pos = 0;
        end else begin
            m_pos++;
        end
        #1;
        if (m_pos == 0) exp = 4'b1001;
        else exp = {frame_bit(m_data, 1'b1, (m_pos - 1) / C0), m_prog, 2'b10};
        check("model", {txd, prog, busy, tx_ready}, exp);
    endtask

    initial begin
        tbl[0] = '{8'hA5, 1'b0, {1'b1, 1'b0, 8'hA5, 1'b0}};
        tbl[1] = '{8'h07, 1'b1, {1'b1, 1'b1, 8'h07, 1'b0}};
        tbl[2] = '{8'h00, 1'b0, {1'b1, 1'b0, 8'h00, 1'b0}};
        tbl[3] = '{8'hFF, 1'b1, {1'b1, 1'b0, 8'hFF, 1'b0}};
        tbl[4] = '{8'h3C, 1'b0, {1'b1, 1'b0, 8'h3C, 1'b0}};
        tbl[5] = '{8'h01, 1'b1, {1'b1, 1'b1, 8'h01, 1'b0}};
        tbl[6] = '{8'h80, 1'b0, {1'b1, 1'b1, 8'h80, 1'b0}};
        tbl[7] = '{8'h5A, 1'b1, {1'b1, 1'b0, 8'h5A, 1'b0}};

        rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; tx_prog = 1'b0;
        d1_valid = 1'b0; d1_data = 8'h00; d1_prog = 1'b0;
        step(); step();
        check("reset_state", {txd, prog, busy, tx_ready}, 4'b1001);
        check("reset_state_1", {d1_txd, d1_progo, d1_busy, d1_ready}, 4'b1001);
        rst_n = 1'b1;
        step();

        // Table-driven frames, data input scrambled during each frame.
        for (int i = 0; i < 8; i++) begin
            tx_data = tbl[i].data; tx_prog = tbl[i].prog; tx_valid = 1'b1;
            step();
            tx_valid = 1'b0;
            for (int t = 1; t <= F0; t++) begin
                if (t > 1) step();
                check("table_frame", {txd, prog, busy, tx_ready},
                      {tbl[i].frame[(t - 1) / C0], tbl[i].prog, 2'b10});
                tx_data = 8'($urandom);
                tx_prog = 1'($urandom);
            end
            step();
            check("table_idle", {txd, prog, busy, tx_ready}, 4'b1001);
        end

        // Back-to-back with tx_valid held: one idle cycle between frames.
        tx_data = 8'h00; tx_prog = 1'b0; tx_valid = 1'b1;
        step();
        tx_data = 8'hFF;
        for (int t = 2; t <= F0; t++) step();
        step();
        check("b2b_gap", {txd, prog, busy, tx_ready}, 4'b1001);
        step();
        check("b2b_second_start", {txd, prog, busy, tx_ready}, 4'b0010);
        tx_valid = 1'b0;
        for (int t = 2; t <= F0; t++) begin
            step();
            if (t == 37) check("b2b_parity_ff", {txd, prog, busy, tx_ready}, 4'b0010);
        end
        step();

        // Reset during data bit 3 of 0x3C.
        tx_data = 8'h3C; tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        for (int t = 2; t <= 18; t++) step();
        check("pre_reset_bit3", {txd, prog, busy, tx_ready}, 4'b1010);
        rst_n = 1'b0;
        step();
        check("reset_midframe", {txd, prog, busy, tx_ready}, 4'b1001);
        rst_n = 1'b1;
        for (int t = 0; t < 50; t++) step();
        check("after_reset_idle", {txd, prog, busy, tx_ready}, 4'b1001);

        // tx_valid during reset is ignored; first valid cycle after release accepts.
        rst_n = 1'b0; tx_valid = 1'b1; tx_data = 8'h55; tx_prog = 1'b1;
        for (int t = 0; t < 3; t++) begin
            step();
            check("valid_in_reset", {txd, prog, busy, tx_ready}, 4'b1001);
        end
        rst_n = 1'b1;
        step();
        check("accept_after_reset", {txd, prog, busy, tx_ready}, 4'b0110);
        tx_valid = 1'b0;
        for (int t = 2; t <= F0 + 1; t++) step();

        // CLKS_PER_BIT=1, no parity: 0x80 gives 0,0,0,0,0,0,0,0,1,1.
        d1_data = 8'h80; d1_prog = 1'b0; d1_valid = 1'b1;
        step();
        d1_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check("c1_frame_80", {d1_txd, d1_progo, d1_busy, d1_ready},
                  {(k >= 8) ? 1'b1 : 1'b0, 3'b010});
            step();
        end
        check("c1_idle", {d1_txd, d1_progo, d1_busy, d1_ready}, 4'b1001);
        for (int n = 0; n < 6; n++) begin
            logic [7:0] d;
            logic       p;
            d = 8'($urandom); p = 1'($urandom);
            d1_data = d; d1_prog = p; d1_valid = 1'b1;
            step();
            d1_valid = 1'b0;
            for (int k = 0; k < 10; k++) begin
                check("c1_rand", {d1_txd, d1_progo, d1_busy, d1_ready},
                      {frame_bit(d, 1'b0, k), p, 2'b10});
                d1_data = 8'($urandom);
                step();
            end
            check("c1_rand_idle", {d1_txd, d1_progo, d1_busy, d1_ready}, 4'b1001);
        end

        // Randomized traffic with occasional resets, checked by the model each cycle.
        for (int n = 0; n < 1500; n++) begin
            tx_valid = ($urandom_range(0, 3) != 0);
            tx_data  = 8'($urandom);
            tx_prog  = 1'($urandom);
            rst_n    = ($urandom_range(0, 199) != 0);
            step();
        end

        rst_n = 1'b1; tx_valid = 1'b0;
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
